// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, default constants and the feedback XOR-reduce
// helper for the Fibonacci LFSR.
//   tap_idx_t   - tap index type for the default 8-bit instance
//   DEF_SEED    - default reset/reload state (8'b1001_0110)
//   DEF_TAPS    - default tap list {0,2,3,4}
//   xor_reduce  - parity of the state bits selected by a tap mask
package lfsr_pkg;

  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_NUM_TAPS = 4;
  localparam int unsigned MAX_REGS     = 64;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] tap_idx_t;

  localparam logic [DEF_NUM_REGS-1:0] DEF_SEED = 8'b1001_0110;
  localparam tap_idx_t DEF_TAPS [DEF_NUM_TAPS-1:0] = '{3'd0, 3'd2, 3'd3, 3'd4};

  // Tap list is folded into a bit mask first, so duplicate taps cancel.
  function automatic logic xor_reduce(input logic [MAX_REGS-1:0] state,
                                      input logic [MAX_REGS-1:0] mask);
    return ^(state & mask);
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// lfsr_feedback: combinational feedback bit for the Fibonacci LFSR.
//   state - current shift-register contents
//   fb_c  - XOR of the tapped state bits
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter logic [$clog2(NUM_REGS)-1:0] TAPS [NUM_TAPS-1:0] = DEF_TAPS
) (
  input  logic [NUM_REGS-1:0] state,
  output logic                fb_c
);

  // Toggle per tap so a repeated index cancels pairwise.
  function automatic logic [NUM_REGS-1:0] build_mask();
    logic [NUM_REGS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      m[TAPS[i]] = ~m[TAPS[i]];
    end
    return m;
  endfunction

  localparam logic [NUM_REGS-1:0] TAP_MASK = build_mask();

  always_comb begin
    fb_c = xor_reduce(MAX_REGS'(state), MAX_REGS'(TAP_MASK));
  end

endmodule

// File: rtl/lfsr.sv
// lfsr: parameterised Fibonacci LFSR, one pseudo-random bit per enabled clock.
//   clk     - rising-edge clock
//   nrst    - asynchronous reset, active HIGH despite the name; loads SEED
//   en      - advance enable, one right shift per enabled edge
//   out_tie - current r[0], straight from the flop
module lfsr
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter logic [NUM_REGS-1:0] SEED = DEF_SEED,
  parameter logic [$clog2(NUM_REGS)-1:0] TAPS [NUM_TAPS-1:0] = DEF_TAPS
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  output logic out_tie
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REGS < 2 || NUM_REGS > MAX_REGS) begin : g_bad_len
    $fatal(1, "lfsr: NUM_REGS=%0d out of range 2..%0d", NUM_REGS, MAX_REGS);
  end
  if (NUM_TAPS < 1 || NUM_TAPS > NUM_REGS) begin : g_bad_ntaps
    $fatal(1, "lfsr: NUM_TAPS=%0d out of range 1..NUM_REGS", NUM_TAPS);
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr: SEED must be non-zero");
  end
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap_chk
    if (32'(TAPS[i]) >= NUM_REGS) begin : g_bad_tap
      $fatal(1, "lfsr: TAPS[%0d]=%0d not below NUM_REGS", i, TAPS[i]);
    end
  end

  logic [NUM_REGS-1:0] r;
  logic                fb_c;

  lfsr_feedback #(
    .NUM_REGS (NUM_REGS),
    .NUM_TAPS (NUM_TAPS),
    .TAPS     (TAPS)
  ) u_feedback (
    .state (r),
    .fb_c  (fb_c)
  );

  // Shift register; reset wins over en, all-zero state reloads SEED.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r <= SEED;
    end else if (en) begin
      if (r == '0) begin
        r <= SEED;
      end else begin
        r <= {fb_c, r[NUM_REGS-1:1]};
      end
    end
  end

  assign out_tie = r[0];

endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: scoreboard bench for the default 8-bit lfsr instance.
module tb_lfsr;

  localparam logic [7:0] SEED = 8'b1001_0110;

  logic clk = 1'b0;
  logic nrst;
  logic en;
  logic out_tie;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  logic [7:0] m_r;

  int tap_list [4] = '{0, 2, 3, 4};

  lfsr dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .out_tie (out_tie)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: parity of tapped bits enters at the top, everything moves down.
  function automatic logic [7:0] model_next(input logic [7:0] s);
    int p;
    if (s == 8'd0) return SEED;
    p = 0;
    foreach (tap_list[i]) p += int'(s[tap_list[i]]);
    return 8'((int'(s) / 2) + (p % 2) * 128);
  endfunction

  function automatic int model_period();
    logic [7:0] s;
    int n;
    s = SEED;
    n = 0;
    do begin
      s = model_next(s);
      n++;
    end while (s != SEED && n < 100000);
    return n;
  endfunction

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic step(input logic e, input logic rs);
    @(negedge clk);
    #2;
    en   = e;
    nrst = rs;
    @(posedge clk);
    if (rs) m_r = SEED;
    else if (e) m_r = model_next(m_r);
    sb.push_back(m_r);
  endtask

  // Monitor: compares DUT state and output against the queue head.
  always @(negedge clk) begin
    logic [7:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_r", 64'(dut.r), 64'(e));
      chk("sb_out", 64'(out_tie), 64'(e[0]));
    end
  end

  logic [7:0] seq_r [5] = '{8'b0100_1011, 8'b0010_0101, 8'b0001_0010,
                            8'b1000_1001, 8'b0100_0100};
  logic       seq_o [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [7:0] hold_v;
    int dut_period;
    int exp_period;

    en   = 1'b0;
    nrst = 1'b0;
    m_r  = SEED;
    #1 nrst = 1'b1;
    #1;
    chk("rst_init_r", 64'(dut.r), 64'(SEED));
    chk("rst_init_out", 64'(out_tie), 64'd0);

    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    #1;
    chk("rst_hold_r", 64'(dut.r), 64'(SEED));
    chk("rst_hold_out", 64'(out_tie), 64'd0);

    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0);
      #1;
      chk("pulse_r", 64'(dut.r), 64'(seq_r[k]));
      chk("pulse_out", 64'(out_tie), 64'(seq_o[k]));
      step(1'b0, 1'b0);
    end

    hold_v = m_r;
    repeat (20) step(1'b0, 1'b0);
    #1;
    chk("hold20_r", 64'(dut.r), 64'(hold_v));

    repeat (300) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // Reset asserted mid-cycle together with en; must act before any edge.
    @(negedge clk);
    #2;
    en   = 1'b1;
    nrst = 1'b1;
    #1;
    chk("async_rst_r", 64'(dut.r), 64'(SEED));
    chk("async_rst_out", 64'(out_tie), 64'd0);
    @(posedge clk);
    m_r = SEED;
    sb.push_back(m_r);
    step(1'b0, 1'b0);

    // Corrupt the state to all-zero, then one enabled edge must reload SEED.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    force dut.r = 8'd0;
    #1;
    release dut.r;
    chk("zero_forced_out", 64'(out_tie), 64'd0);
    m_r = 8'd0;
    step(1'b1, 1'b0);
    #1;
    chk("lockup_reload", 64'(dut.r), 64'(SEED));

    exp_period = model_period();
    dut_period = 0;
    for (int n = 1; n <= 1000; n++) begin
      step(1'b1, 1'b0);
      #1;
      if (dut.r == SEED) begin
        dut_period = n;
        break;
      end
    end
    chk("period", 64'(dut_period), 64'(exp_period));

    step(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
